// File: rtl/bus_arbiter2.sv
// Two-master / one-slave bus arbiter with round-robin or fixed priority.
// Optional BUS_TIMEOUT_EN macro adds a watchdog that aborts a silent slave.
module bus_arbiter2 #(
   parameter int PRIO_FIXED = 0,
   parameter int TO_W       = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_data_o,
   input  logic        m0_rd_n,
   input  logic        m0_wr_n,
   input  logic [3:0]  m0_be,
   output logic [31:0] m0_data_i,
   output logic        m0_rdy,
   output logic        m0_acc_fault,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_data_o,
   input  logic        m1_rd_n,
   input  logic        m1_wr_n,
   input  logic [3:0]  m1_be,
   output logic [31:0] m1_data_i,
   output logic        m1_rdy,
   output logic        m1_acc_fault,
   output logic [31:0] s_addr,
   output logic [31:0] s_data_o,
   output logic        s_rd_n,
   output logic        s_wr_n,
   output logic [3:0]  s_be,
   input  logic [31:0] s_data_i,
   input  logic        s_rdy,
   input  logic        s_acc_fault,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       last_m1_q, last_m1_d;
   logic       m0_req_s, m1_req_s, own_req_s, busy_s, resp_s, timeout_s;
   logic [1:0] pick_s;

   assign m0_req_s  = ~m0_rd_n | ~m0_wr_n;
   assign m1_req_s  = ~m1_rd_n | ~m1_wr_n;
   assign busy_s    = (state_q == ST_BUSY);
   assign resp_s    = s_rdy | s_acc_fault;
   assign own_req_s = (grant_q[0] & m0_req_s) | (grant_q[1] & m1_req_s);
   assign m0_data_i = s_data_i;
   assign m1_data_i = s_data_i;

`ifdef BUS_TIMEOUT_EN
   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE) begin
         cnt_d = {TO_W{1'b0}};
      end else if (busy_s && !resp_s) begin
         cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {TO_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_s = busy_s && (cnt_q == TO_W'(TIMEOUT));
`else
   assign timeout_s = 1'b0;
`endif

   // Tie-break: fixed priority favours m0, round-robin favours whoever was not last granted.
   always_comb begin
      pick_s = 2'b00;
      if (m0_req_s && m1_req_s) begin
         if (PRIO_FIXED != 0) begin
            pick_s = 2'b01;
         end else begin
            pick_s = last_m1_q ? 2'b01 : 2'b10;
         end
      end else if (m0_req_s) begin
         pick_s = 2'b01;
      end else if (m1_req_s) begin
         pick_s = 2'b10;
      end else begin
         pick_s = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= 2'b00;
         last_m1_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_m1_q <= last_m1_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_m1_d = last_m1_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_s != 2'b00) begin
               state_d   = ST_BUSY;
               grant_d   = pick_s;
               last_m1_d = pick_s[1];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (resp_s || !own_req_s || timeout_s) begin
               state_d = ST_TURN;
               grant_d = 2'b00;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_TURN: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // Slave side mirrors the owner combinationally; everything is parked outside BUSY.
   always_comb begin
      s_addr       = 32'h0000_0000;
      s_data_o     = 32'h0000_0000;
      s_rd_n       = 1'b1;
      s_wr_n       = 1'b1;
      s_be         = 4'b0000;
      m0_rdy       = 1'b0;
      m0_acc_fault = 1'b0;
      m1_rdy       = 1'b0;
      m1_acc_fault = 1'b0;
      owner        = 2'b00;
      if (busy_s && grant_q[0]) begin
         s_addr       = m0_addr;
         s_data_o     = m0_data_o;
         s_rd_n       = m0_rd_n;
         s_wr_n       = m0_wr_n;
         s_be         = m0_be;
         m0_rdy       = s_rdy;
         m0_acc_fault = s_acc_fault | timeout_s;
         owner        = 2'b01;
      end else if (busy_s && grant_q[1]) begin
         s_addr       = m1_addr;
         s_data_o     = m1_data_o;
         s_rd_n       = m1_rd_n;
         s_wr_n       = m1_wr_n;
         s_be         = m1_be;
         m1_rdy       = s_rdy;
         m1_acc_fault = s_acc_fault | timeout_s;
         owner        = 2'b10;
      end else begin
         owner = 2'b00;
      end
   end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: round-robin and fixed-priority instances share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_bus_arbiter2;

   localparam int TMO = 4;
`ifdef BUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_addr, m0_data_o, m1_addr, m1_data_o, s_data_i;
   logic        m0_rd_n, m0_wr_n, m1_rd_n, m1_wr_n, s_rdy, s_acc_fault;
   logic [3:0]  m0_be, m1_be;

   logic [31:0] m0_data_i_w [2];
   logic [31:0] m1_data_i_w [2];
   logic [31:0] s_addr_w    [2];
   logic [31:0] s_data_o_w  [2];
   logic        m0_rdy_w    [2];
   logic        m1_rdy_w    [2];
   logic        m0_af_w     [2];
   logic        m1_af_w     [2];
   logic        s_rd_n_w    [2];
   logic        s_wr_n_w    [2];
   logic [3:0]  s_be_w      [2];
   logic [1:0]  own_w       [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      bus_arbiter2 #(.PRIO_FIXED(g), .TO_W(8), .TIMEOUT(TMO)) u_dut (
         .clk(clk), .rst(rst),
         .m0_addr(m0_addr), .m0_data_o(m0_data_o), .m0_rd_n(m0_rd_n), .m0_wr_n(m0_wr_n),
         .m0_be(m0_be), .m0_data_i(m0_data_i_w[g]), .m0_rdy(m0_rdy_w[g]), .m0_acc_fault(m0_af_w[g]),
         .m1_addr(m1_addr), .m1_data_o(m1_data_o), .m1_rd_n(m1_rd_n), .m1_wr_n(m1_wr_n),
         .m1_be(m1_be), .m1_data_i(m1_data_i_w[g]), .m1_rdy(m1_rdy_w[g]), .m1_acc_fault(m1_af_w[g]),
         .s_addr(s_addr_w[g]), .s_data_o(s_data_o_w[g]), .s_rd_n(s_rd_n_w[g]), .s_wr_n(s_wr_n_w[g]),
         .s_be(s_be_w[g]), .s_data_i(s_data_i), .s_rdy(s_rdy), .s_acc_fault(s_acc_fault),
         .owner(own_w[g])
      );
   end

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model: who holds the bus, cycles left before a new grant may happen,
   // who won last, and how many BUSY cycles the current transfer has lasted.
   int mown  [2];
   int mgap  [2];
   int mlast [2];
   int mbusy [2];

   // Per-instance observations used by the directed scenarios.
   int rdlow [2], wrlow [2], r0cnt [2], r1cnt [2], f0cnt [2], f0_at [2], busyc [2];
   logic [1:0] snap_own [2];
   logic       snap_rd  [2];
   logic [3:0] snap_be  [2];
   logic [1:0] gq0 [$], gq1 [$];
   int         gc0 [$];
   logic [31:0] cap0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_timeout(int p);
      return TO_EN && (mown[p] != 0) && (mbusy[p] == TMO);
   endfunction

   task automatic check_dut(int p);
      logic [31:0] e_addr = 32'h0, e_data = 32'h0;
      logic        e_rd = 1'b1, e_wr = 1'b1, e_r0 = 1'b0, e_r1 = 1'b0, e_f0 = 1'b0, e_f1 = 1'b0;
      logic [3:0]  e_be = 4'h0;
      logic [1:0]  e_own = 2'b00;
      bit          to = m_timeout(p);
      if (mown[p] == 1) begin
         e_addr = m0_addr; e_data = m0_data_o; e_rd = m0_rd_n; e_wr = m0_wr_n; e_be = m0_be;
         e_r0 = s_rdy; e_f0 = s_acc_fault | to; e_own = 2'b01;
      end else if (mown[p] == 2) begin
         e_addr = m1_addr; e_data = m1_data_o; e_rd = m1_rd_n; e_wr = m1_wr_n; e_be = m1_be;
         e_r1 = s_rdy; e_f1 = s_acc_fault | to; e_own = 2'b10;
      end
      chk($sformatf("p%0d owner", p),    {30'h0, own_w[p]},  {30'h0, e_own});
      chk($sformatf("p%0d s_addr", p),   s_addr_w[p],        e_addr);
      chk($sformatf("p%0d s_data_o", p), s_data_o_w[p],      e_data);
      chk($sformatf("p%0d s_rd_n", p),   {31'h0, s_rd_n_w[p]}, {31'h0, e_rd});
      chk($sformatf("p%0d s_wr_n", p),   {31'h0, s_wr_n_w[p]}, {31'h0, e_wr});
      chk($sformatf("p%0d s_be", p),     {28'h0, s_be_w[p]}, {28'h0, e_be});
      chk($sformatf("p%0d m0_rdy", p),   {31'h0, m0_rdy_w[p]}, {31'h0, e_r0});
      chk($sformatf("p%0d m1_rdy", p),   {31'h0, m1_rdy_w[p]}, {31'h0, e_r1});
      chk($sformatf("p%0d m0_fault", p), {31'h0, m0_af_w[p]},  {31'h0, e_f0});
      chk($sformatf("p%0d m1_fault", p), {31'h0, m1_af_w[p]},  {31'h0, e_f1});
      chk($sformatf("p%0d m0_data_i", p), m0_data_i_w[p],   s_data_i);
      chk($sformatf("p%0d m1_data_i", p), m1_data_i_w[p],   s_data_i);
   endtask

   task automatic model_step(int p);
      bit r0 = !m0_rd_n || !m0_wr_n;
      bit r1 = !m1_rd_n || !m1_wr_n;
      bit to = m_timeout(p);
      bit req;
      int w;
      if (rst) begin
         mown[p] = 0; mgap[p] = 0; mlast[p] = 2; mbusy[p] = 0;
      end else if (mown[p] != 0) begin
         req = (mown[p] == 1) ? r0 : r1;
         if (s_rdy || s_acc_fault || !req || to) begin
            mown[p] = 0; mgap[p] = 1;
         end else begin
            mbusy[p]++;
         end
      end else if (mgap[p] > 0) begin
         mgap[p]--;
      end else if (r0 || r1) begin
         if (r0 && r1) w = (p == 1) ? 1 : ((mlast[p] == 1) ? 2 : 1);
         else          w = r0 ? 1 : 2;
         mown[p] = w; mlast[p] = w; mbusy[p] = 0;
      end
   endtask

   task automatic clear_stats();
      for (int p = 0; p < 2; p++) begin
         rdlow[p] = 0; wrlow[p] = 0; r0cnt[p] = 0; r1cnt[p] = 0;
         f0cnt[p] = 0; f0_at[p] = 0; busyc[p] = 0;
      end
      gq0.delete(); gq1.delete(); gc0.delete();
   endtask

   // One bus cycle: check outputs mid-cycle, then advance the model past the rising edge.
   task automatic tick();
      #1;
      for (int p = 0; p < 2; p++) begin
         check_dut(p);
         snap_own[p] = own_w[p]; snap_rd[p] = s_rd_n_w[p]; snap_be[p] = s_be_w[p];
         if (!s_rd_n_w[p]) rdlow[p]++;
         if (!s_wr_n_w[p]) wrlow[p]++;
         if (m0_rdy_w[p]) r0cnt[p]++;
         if (m1_rdy_w[p]) r1cnt[p]++;
         if (own_w[p] != 2'b00) busyc[p]++;
         if (m0_af_w[p]) begin f0cnt[p]++; f0_at[p] = busyc[p]; end
      end
      if (m0_rdy_w[0]) cap0 = m0_data_i_w[0];
      if (own_w[0] != 2'b00) begin gq0.push_back(own_w[0]); gc0.push_back(cyc); end
      if (own_w[1] != 2'b00) gq1.push_back(own_w[1]);
      cyc++;
      @(posedge clk);
      #1;
      model_step(0);
      model_step(1);
      @(negedge clk);
   endtask

   task automatic bus_idle();
      m0_rd_n = 1'b1; m0_wr_n = 1'b1; m1_rd_n = 1'b1; m1_wr_n = 1'b1;
      m0_addr = 32'h0; m0_data_o = 32'h0; m0_be = 4'h0;
      m1_addr = 32'h0; m1_data_o = 32'h0; m1_be = 4'h0;
      s_rdy = 1'b0; s_acc_fault = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic rand_master(int i);
      int kind;
      if ($urandom_range(3) == 0) begin
         kind = $urandom_range(3);
         if (i == 0) begin
            m0_rd_n = !(kind == 1 || kind == 3); m0_wr_n = !(kind == 2);
            m0_addr = $urandom; m0_data_o = $urandom; m0_be = 4'($urandom_range(15));
         end else begin
            m1_rd_n = !(kind == 1 || kind == 3); m1_wr_n = !(kind == 2);
            m1_addr = $urandom; m1_data_o = $urandom; m1_be = 4'($urandom_range(15));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      s_data_i = 32'h0;
      bus_idle();
      for (int p = 0; p < 2; p++) begin
         mown[p] = 0; mgap[p] = 0; mlast[p] = 2; mbusy[p] = 0;
      end
      @(negedge clk);
      do_reset();

      // m0 read answered on the third BUSY cycle
      clear_stats();
      cap0 = 32'h0;
      m0_addr = 32'h0000_1000; m0_be = 4'b1111; m0_rd_n = 1'b0;
      tick(); tick(); tick();
      s_rdy = 1'b1; s_data_i = 32'hDEAD_BEEF;
      tick();
      bus_idle();
      tick(); tick();
      chk("t1 rd_low_cycles", rdlow[0], 32'd3);
      chk("t1 m0_rdy_pulses", r0cnt[0], 32'd1);
      chk("t1 m1_rdy_pulses", r1cnt[0], 32'd0);
      chk("t1 m0_read_data", cap0, 32'hDEAD_BEEF);

      // both masters request continuously, slave always ready
      do_reset();
      clear_stats();
      m0_rd_n = 1'b0; m0_addr = 32'h100; m1_rd_n = 1'b0; m1_addr = 32'h200;
      s_rdy = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      bus_idle();
      tick(); tick();
      chk("t2 rr_grant_count", gq0.size(), 32'd4);
      chk("t2 fix_grant_count", gq1.size(), 32'd4);
      for (int k = 0; k < 4 && k < gq0.size(); k++) begin
         chk($sformatf("t2 rr_grant%0d", k), {30'h0, gq0[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k > 0) chk($sformatf("t2 rr_spacing%0d", k), gc0[k] - gc0[k-1], 32'd3);
      end
      for (int k = 0; k < gq1.size(); k++)
         chk($sformatf("t2 fix_grant%0d", k), {30'h0, gq1[k]}, 32'd1);

      // m1 write aborted by the master before any response
      clear_stats();
      m1_wr_n = 1'b0; m1_addr = 32'h10; m1_data_o = 32'hA5A5_A5A5; m1_be = 4'b0011;
      tick(); tick();
      m1_wr_n = 1'b1;
      tick();
      chk("t3 s_wr_n_after_abort", {31'h0, s_wr_n_w[0]}, 32'd1);
      tick();
      chk("t3 turn_owner", {30'h0, snap_own[0]}, 32'd0);
      tick(); tick();
      chk("t3 m1_rdy_pulses", r1cnt[0], 32'd0);
      chk("t3 wr_low_cycles", wrlow[0], 32'd1);
      chk("t3 busy_cycles", busyc[0], 32'd2);

`ifdef BUS_TIMEOUT_EN
      // silent slave: watchdog fault on the fifth BUSY cycle
      clear_stats();
      m0_rd_n = 1'b0; m0_addr = 32'h300; m0_be = 4'hF;
      for (int k = 0; k < 7; k++) tick();
      chk("t4 fault_pulses", f0cnt[0], 32'd1);
      chk("t4 fault_busy_cycle", f0_at[0], 32'd5);
      chk("t4 busy_cycles", busyc[0], 32'd5);
      bus_idle();
      tick(); tick();
`endif

      // reset during the second BUSY cycle of an m1 read
      do_reset();
      clear_stats();
      m1_rd_n = 1'b0; m1_addr = 32'h400; m1_be = 4'hF;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m0_rd_n = 1'b0; m0_addr = 32'h500; m0_be = 4'hF;
      tick();
      chk("t5 owner_after_rst", {30'h0, snap_own[0]}, 32'd0);
      chk("t5 rd_n_after_rst", {31'h0, snap_rd[0]}, 32'd1);
      chk("t5 be_after_rst", {28'h0, snap_be[0]}, 32'd0);
      tick();
      chk("t5 rr_winner", {30'h0, snap_own[0]}, 32'd1);
      chk("t5 fix_winner", {30'h0, snap_own[1]}, 32'd1);
      chk("t5 m1_rdy_pulses", r1cnt[0], 32'd0);
      bus_idle();
      tick(); tick();

      // random traffic against the reference model
      for (int k = 0; k < 3000; k++) begin
         rand_master(0);
         rand_master(1);
         s_rdy       = ($urandom_range(3) == 0);
         s_acc_fault = ($urandom_range(11) == 0);
         s_data_i    = $urandom;
         rst         = ($urandom_range(199) == 0);
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
